// File: rtl/controlador_palavra.sv
// controlador_palavra: queues entered notes, feeds them one at a time to the
// word classifier and latches the classifier's verdict when a word ends.
// Optional feature macro: CONTROLADOR_TIMEOUT_EN (word-end timeout and Erro flag).
module controlador_palavra #(
  parameter int PROFUNDIDADE  = 8,
  parameter int LIMITE_ESPERA = 15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Entrada_valida,
  input  logic       Tom_in,
  input  logic [2:0] Nota_in,
  input  logic       End,
  input  logic [1:0] Tipo,
  output logic       Tom,
  output logic [2:0] Nota,
  output logic       Ready,
  output logic [1:0] Tipo_final,
  output logic       Palavra_pronta,
  output logic [3:0] Contador_palavras,
  output logic       Cheio,
  output logic       Vazio,
  output logic       Estouro,
  output logic       Erro
);

  localparam int PTR_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OCIOSO,
    ENVIA,
    ESPERA_FIM,
    CONCLUI
  } estado_t;

  estado_t          estado;
  logic [3:0]       mem [PROFUNDIDADE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] ocupacao;
  logic             push;
  logic             pop;

`ifdef CONTROLADOR_TIMEOUT_EN
  localparam int TIMER_W = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA + 1) : 1;
  logic [TIMER_W-1:0] espera;
  logic               erro_q;
`endif

  // The head entry is consumed during the single ENVIA cycle; a full FIFO
  // still accepts a new entry in that cycle because a slot frees up.
  assign pop   = (estado == ENVIA);
  assign Cheio = (ocupacao == OCC_W'(PROFUNDIDADE));
  assign Vazio = (ocupacao == '0);
  assign push  = Entrada_valida && (!Cheio || pop);

  // Note storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {Tom_in, Nota_in};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ocupacao <= '0;
      Estouro  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        ocupacao <= ocupacao + OCC_W'(1);
      end else if (pop && !push) begin
        ocupacao <= ocupacao - OCC_W'(1);
      end
      if (Entrada_valida && !push) begin
        Estouro <= 1'b1;
      end
    end
  end

  // Word sequencer; outputs are loaded on the edge entering a state so that
  // Ready is high during ENVIA and Palavra_pronta is high during CONCLUI.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      estado            <= OCIOSO;
      Ready             <= 1'b0;
      Tom               <= 1'b0;
      Nota              <= 3'b000;
      Tipo_final        <= 2'b00;
      Palavra_pronta    <= 1'b0;
      Contador_palavras <= 4'd0;
`ifdef CONTROLADOR_TIMEOUT_EN
      espera            <= '0;
      erro_q            <= 1'b0;
`endif
    end else begin
      Ready          <= 1'b0;
      Palavra_pronta <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (!Vazio) begin
            estado      <= ENVIA;
            Ready       <= 1'b1;
            {Tom, Nota} <= mem[rd_ptr];
          end
        end
        ENVIA: begin
          if (Nota == 3'b000) begin
            estado <= ESPERA_FIM;
`ifdef CONTROLADOR_TIMEOUT_EN
            espera <= '0;
`endif
          end else begin
            estado <= OCIOSO;
          end
        end
        ESPERA_FIM: begin
          if (End) begin
            estado            <= CONCLUI;
            Tipo_final        <= Tipo;
            Palavra_pronta    <= 1'b1;
            Contador_palavras <= Contador_palavras + 4'd1;
          end
`ifdef CONTROLADOR_TIMEOUT_EN
          else if (espera == TIMER_W'(LIMITE_ESPERA - 1)) begin
            estado            <= CONCLUI;
            Tipo_final        <= 2'b00;
            Palavra_pronta    <= 1'b1;
            Contador_palavras <= Contador_palavras + 4'd1;
            erro_q            <= 1'b1;
          end else begin
            espera <= espera + TIMER_W'(1);
          end
`endif
        end
        CONCLUI: begin
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

`ifdef CONTROLADOR_TIMEOUT_EN
  assign Erro = erro_q;
`else
  // No timer exists in this build, so a word can never end in error.
  assign Erro = (LIMITE_ESPERA < 0);
`endif

endmodule

// File: tb/tb_controlador_palavra.sv
// tb_controlador_palavra: directed self-checking bench for controlador_palavra.
// Covers reset, word sequencing, FIFO overflow and push-during-pop, the
// word-end wait (timeout or indefinite depending on CONTROLADOR_TIMEOUT_EN),
// word-counter wrap and asynchronous reset mid-word.
module tb_controlador_palavra;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Entrada_valida = 1'b0;
  logic       Tom_in = 1'b0;
  logic [2:0] Nota_in = 3'b000;
  logic       End = 1'b0;
  logic [1:0] Tipo = 2'b00;
  logic       Tom;
  logic [2:0] Nota;
  logic       Ready;
  logic [1:0] Tipo_final;
  logic       Palavra_pronta;
  logic [3:0] Contador_palavras;
  logic       Cheio;
  logic       Vazio;
  logic       Estouro;
  logic       Erro;

  int         n_checks = 0;
  int         n_fails = 0;
  int         cycle = 0;
  int         pronta_count = 0;
  logic [3:0] ready_log [$];
  int         ready_cyc [$];
  logic [3:0] drain_exp [9];

  controlador_palavra #(
    .PROFUNDIDADE (8),
    .LIMITE_ESPERA(15)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .Entrada_valida   (Entrada_valida),
    .Tom_in           (Tom_in),
    .Nota_in          (Nota_in),
    .End              (End),
    .Tipo             (Tipo),
    .Tom              (Tom),
    .Nota             (Nota),
    .Ready            (Ready),
    .Tipo_final       (Tipo_final),
    .Palavra_pronta   (Palavra_pronta),
    .Contador_palavras(Contador_palavras),
    .Cheio            (Cheio),
    .Vazio            (Vazio),
    .Estouro          (Estouro),
    .Erro             (Erro)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and log every Ready / Palavra_pronta pulse seen.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (Ready) begin
      ready_log.push_back({Tom, Nota});
      ready_cyc.push_back(cycle);
    end
    if (Palavra_pronta) pronta_count++;
  endtask

  // Enqueue one note with a one-cycle strobe.
  task automatic applyStimulus(input logic tom, input logic [2:0] nota);
    Entrada_valida = 1'b1;
    Tom_in         = tom;
    Nota_in        = nota;
    tick();
    Entrada_valida = 1'b0;
  endtask

  // Tick until the Ready log reaches the target size, within a budget.
  task automatic wait_ready(input int target, input int budget);
    int n;
    n = 0;
    while (ready_log.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wait_ready", ready_log.size() >= target, 1);
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_vazio"}, Vazio, 1);
    checkOutput({pfx, "_cheio"}, Cheio, 0);
    checkOutput({pfx, "_ready"}, Ready, 0);
    checkOutput({pfx, "_tom"}, Tom, 0);
    checkOutput({pfx, "_nota"}, Nota, 0);
    checkOutput({pfx, "_tipo_final"}, Tipo_final, 0);
    checkOutput({pfx, "_pronta"}, Palavra_pronta, 0);
    checkOutput({pfx, "_contador"}, Contador_palavras, 0);
    checkOutput({pfx, "_estouro"}, Estouro, 0);
    checkOutput({pfx, "_erro"}, Erro, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int p;
    int r;

    // Reset state
    #12;
    check_reset_values("rst");
    Reset = 1'b1;

    // Three-note word 011, 100, 000 then End with Tipo=10
    applyStimulus(1'b0, 3'b011);
    applyStimulus(1'b0, 3'b100);
    applyStimulus(1'b0, 3'b000);
    wait_ready(3, 20);
    checkOutput("word_note0", ready_log[0], 4'b0011);
    checkOutput("word_note1", ready_log[1], 4'b0100);
    checkOutput("word_note2", ready_log[2], 4'b0000);
    checkOutput("ready_gap01", (ready_cyc[1] - ready_cyc[0]) >= 2, 1);
    checkOutput("ready_gap12", (ready_cyc[2] - ready_cyc[1]) >= 2, 1);
    tick();
    End  = 1'b1;
    Tipo = 2'b10;
    tick();
    checkOutput("word1_pronta", Palavra_pronta, 1);
    checkOutput("word1_tipo", Tipo_final, 2'b10);
    checkOutput("word1_count", Contador_palavras, 1);
    End  = 1'b0;
    Tipo = 2'b00;
    tick();
    checkOutput("word1_pronta_off", Palavra_pronta, 0);
    checkOutput("word1_pulses", pronta_count, 1);

    // Overflow while stalled waiting for End
    applyStimulus(1'b0, 3'b000);
    wait_ready(4, 10);
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drain_exp[k] = {k[0], 3'((k % 7) + 1)};
      applyStimulus(k[0], 3'((k % 7) + 1));
      if (k == 7) begin
        checkOutput("full8_cheio", Cheio, 1);
        checkOutput("full8_vazio", Vazio, 0);
        checkOutput("full8_estouro", Estouro, 0);
      end
    end
    drain_exp[8] = 4'b1101;
    checkOutput("drop9_cheio", Cheio, 1);
    checkOutput("drop9_estouro", Estouro, 1);
    checkOutput("drop9_vazio", Vazio, 0);
    checkOutput("stall_no_ready", ready_log.size(), 4);
    End  = 1'b1;
    Tipo = 2'b01;
    tick();
    checkOutput("word2_pronta", Palavra_pronta, 1);
    checkOutput("word2_tipo", Tipo_final, 2'b01);
    checkOutput("word2_count", Contador_palavras, 2);
    End  = 1'b0;

    // Push while full during the ENVIA pop
    wait_ready(5, 10);
    checkOutput("popfull_cheio_before", Cheio, 1);
    applyStimulus(1'b1, 3'b101);
    checkOutput("popfull_cheio", Cheio, 1);
    checkOutput("popfull_estouro", Estouro, 1);
    wait_ready(13, 40);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("drain%0d", i), ready_log[4 + i], drain_exp[i]);
    end
    repeat (3) tick();
    checkOutput("drained_vazio", Vazio, 1);
    checkOutput("drained_cheio", Cheio, 0);

    // Waiting for End with End held low
    Tipo = 2'b11;
    checkOutput("erro_before", Erro, 0);
    applyStimulus(1'b0, 3'b000);
    wait_ready(14, 10);
`ifdef CONTROLADOR_TIMEOUT_EN
    n = 0;
    p = pronta_count;
    while (pronta_count == p && n < 40) begin
      tick();
      n++;
    end
    checkOutput("timeout_latency", n, 16);
    checkOutput("timeout_tipo", Tipo_final, 2'b00);
    checkOutput("timeout_erro", Erro, 1);
    checkOutput("timeout_count", Contador_palavras, 3);
`else
    p = pronta_count;
    repeat (100) tick();
    checkOutput("noto_no_pronta", pronta_count, p);
    checkOutput("noto_erro", Erro, 0);
    End = 1'b1;
    tick();
    checkOutput("noto_pronta", Palavra_pronta, 1);
    checkOutput("noto_tipo", Tipo_final, 2'b11);
    checkOutput("noto_count", Contador_palavras, 3);
    End = 1'b0;
`endif
    Tipo = 2'b00;
    tick();

    // Asynchronous reset between Ready pulses of a word
    applyStimulus(1'b0, 3'b011);
    applyStimulus(1'b0, 3'b000);
    wait_ready(15, 10);
    tick();
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("async");
    #2;
    Reset = 1'b1;
    p = pronta_count;
    r = ready_log.size();
    End = 1'b1;
    repeat (5) tick();
    End = 1'b0;
    checkOutput("async_no_pronta", pronta_count, p);
    checkOutput("async_no_ready", ready_log.size(), r);
    checkOutput("async_count", Contador_palavras, 0);
    checkOutput("async_vazio", Vazio, 1);

    // Sixteen complete words: counter climbs to 15 then wraps to 0
    for (int w = 0; w < 16; w++) begin
      Tipo = w[1:0];
      applyStimulus(1'b0, 3'b000);
      wait_ready(r + 1 + w, 10);
      tick();
      End = 1'b1;
      tick();
      End = 1'b0;
      checkOutput($sformatf("wrap%0d_pronta", w), Palavra_pronta, 1);
      checkOutput($sformatf("wrap%0d_count", w), Contador_palavras, (w + 1) % 16);
      checkOutput($sformatf("wrap%0d_tipo", w), Tipo_final, w % 4);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/controlador_palavra.md
CONTROLADOR_PALAVRA -- requirements
Module: controlador_palavra

Interface
REQ-001 SHALL have parameter PROFUNDIDADE, default 8, FIFO depth in note entries (power of 2, 2..16).
REQ-002 SHALL have parameter LIMITE_ESPERA, default 15, max cycles waiting for End after a terminator.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Entrada_valida  input  1  one-cycle strobe: Tom_in/Nota_in hold a note to enqueue.
REQ-006 Tom_in  input  1  tone of entered note.
REQ-007 Nota_in  input  3  note code of entered note (000 = invalid/terminator).
REQ-008 End  input  1  word-end flag from classifier.
REQ-009 Tipo  input  2  word type from classifier.
REQ-010 Tom  output  1  tone presented to classifier.
REQ-011 Nota  output  3  note presented to classifier.
REQ-012 Ready  output  1  one-cycle "note valid" pulse to classifier.
REQ-013 Tipo_final  output  2  latched type of last finished word.
REQ-014 Palavra_pronta  output  1  one-cycle pulse, Tipo_final updated.
REQ-015 Contador_palavras  output  4  finished-word count.
REQ-016 Cheio / Vazio  output  1 each  FIFO full / empty.
REQ-017 Estouro  output  1  sticky: an entry was dropped while full.
REQ-018 Erro  output  1  sticky: a word ended by timeout.

Function
REQ-019 FIFO SHALL store {Tom_in,Nota_in}; write when Entrada_valida=1 and (not full or pop same cycle).
REQ-020 Write while full without same-cycle pop SHALL drop the entry and set Estouro.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo PROFUNDIDADE.
REQ-022 FSM states: OCIOSO, ENVIA, ESPERA_FIM, CONCLUI.
REQ-023 OCIOSO: if FIFO non-empty -> ENVIA next cycle; else stay.
REQ-024 ENVIA: pop head, drive Tom/Nota from it, Ready=1 for exactly this one cycle; if Nota of popped entry = 000 -> ESPERA_FIM, else -> OCIOSO.
REQ-025 Tom/Nota SHALL hold last sent value until next ENVIA.
REQ-026 ESPERA_FIM: End=1 -> CONCLUI; timeout counter per Configuration.
REQ-027 CONCLUI: Tipo_final<=Tipo (00 if timed out), Palavra_pronta=1 one cycle, Contador_palavras+1 (15 wraps to 0), -> OCIOSO.
REQ-028 Minimum spacing between Ready pulses SHALL be 2 cycles; one word termination latency (ENVIA to Palavra_pronta) = 2 cycles when End arrives the cycle after Ready.
REQ-029 FIFO writes SHALL continue in every state.

Reset
REQ-030 Reset=0 SHALL immediately clear FIFO (Vazio=1, Cheio=0), FSM to OCIOSO, Ready=0, Tom=0, Nota=000, Tipo_final=00, Palavra_pronta=0, Contador_palavras=0, Estouro=0, Erro=0, timeout counter=0.
REQ-031 Reset mid-word SHALL abandon word without Palavra_pronta or count change; first edge after release SHALL behave as OCIOSO.

Configuration
REQ-032 Macro CONTROLADOR_TIMEOUT_EN defined: ESPERA_FIM counts cycles; after LIMITE_ESPERA cycles without End -> CONCLUI with Tipo_final=00, Erro set.
REQ-033 Macro undefined: no timeout counter, ESPERA_FIM waits indefinitely for End, Erro tied 0.

Verification
REQ-034 Reset, enqueue notes 011,100,000 (Tom=0) -> three Ready pulses in order 011,100,000, each 2+ cycles apart; End then Tipo=10 -> Tipo_final=10, one Palavra_pronta, count=1.
REQ-035 Enqueue 9 notes with FSM stalled in ESPERA_FIM, depth 8 -> Cheio=1 after 8th, 9th dropped, Estouro=1, Vazio=0.
REQ-036 Full FIFO, Entrada_valida during ENVIA pop -> write accepted, occupancy stays 8, Estouro unchanged.
REQ-037 Macro defined, send 000, hold End=0 -> after 15 cycles Palavra_pronta, Tipo_final=00, Erro=1; macro undefined -> no Palavra_pronta after 100 cycles.
REQ-038 16 complete words -> Contador_palavras goes 15 then 0.
REQ-039 Reset=0 asserted asynchronously between Ready pulses of a word -> all outputs at reset values before next clk edge; no count increment.
